// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   REG_AW   - default register address width
//   state_e  - controller state encoding
//   FWD_*    - ALU forwarding mux select values
package hazard_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational ALU-result forwarding select for one EX operand.
//   rs_i                         source register of the EX operand
//   rd_mem_i / regwrite_mem_i    MEM-stage writer
//   memread_mem_i                MEM-stage instruction is a load (no ALU result yet)
//   rd_wb_i / regwrite_wb_i      WB-stage writer
//   fwd_sel_o                    FWD_RF / FWD_MEM / FWD_WB
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned AW = REG_AW
) (
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rd_mem_i,
    input  logic          regwrite_mem_i,
    input  logic          memread_mem_i,
    input  logic [AW-1:0] rd_wb_i,
    input  logic          regwrite_wb_i,
    output logic [1:0]    fwd_sel_o
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a write to it is never a forwarding source.
    assign mem_hit = regwrite_mem_i && !memread_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i);
    assign wb_hit  = regwrite_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs_i);

    always_comb begin
        fwd_sel_o = FWD_RF;
        if (mem_hit) begin
            fwd_sel_o = FWD_MEM;   // youngest result wins
        end else if (wb_hit) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RV32I pipeline.
//   Inputs : ID/EX/MEM/WB register addresses and control bits, taken-branch
//            flag from EX, data-memory busy.
//   Outputs: pc_hold / ifid_hold / idex_bubble / ifid_flush / pipe_freeze
//            pipeline controls, stall_EN1_EX / stall_EN2_EX load-data operand
//            selects, fwd1_sel / fwd2_sel ALU forwarding selects, stall_cnt
//            saturating count of cycles with pc_hold asserted.
module hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              rs1_used_ID,
    input  logic              rs2_used_ID,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              memread_EX,
    input  logic              regwrite_EX,
    input  logic [REG_AW-1:0] rs1_EX,
    input  logic [REG_AW-1:0] rs2_EX,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic              regwrite_MEM,
    input  logic              memread_MEM,
    input  logic [REG_AW-1:0] rd_WB,
    input  logic              regwrite_WB,
    input  logic              branch_taken_EX,
    input  logic              mem_busy,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              pipe_freeze,
    output logic              stall_EN1_EX,
    output logic              stall_EN2_EX,
    output logic [1:0]        fwd1_sel,
    output logic [1:0]        fwd2_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    import hazard_pkg::*;

    state_e             state_q, state_d;
    state_e             saved_q, saved_d;
    state_e             eff_state;
    logic               en1_q, en1_d;
    logic               en2_q, en2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               m1, m2, lu;
    logic [1:0]         fwd1_raw, fwd2_raw;

    assign m1 = rs1_used_ID && (rs1_ID == rd_EX);
    assign m2 = rs2_used_ID && (rs2_ID == rd_EX);
    assign lu = memread_EX && regwrite_EX && (rd_EX != '0) && (m1 || m2);

    // Once memory is ready again, MEM_WAIT behaves as the saved state in the
    // same cycle, so a frozen LU_STALL still gets exactly one flag cycle.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            saved_q <= RUN;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        en1_d   = en1_q;
        en2_d   = en2_q;
        if (mem_busy) begin
            state_d = MEM_WAIT;
            saved_d = eff_state;
        end else begin
            state_d = RUN;
            en1_d   = 1'b0;
            en2_d   = 1'b0;
            if (eff_state == RUN && !branch_taken_EX && lu) begin
                state_d = LU_STALL;
                en1_d   = m1;
                en2_d   = m2;
            end
        end
        cnt_d = cnt_q;
        if (pc_hold && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output logic
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
        end else if (branch_taken_EX) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (eff_state == RUN && lu) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    fwd_unit #(.AW(REG_AW)) u_fwd1 (
        .rs_i           (rs1_EX),
        .rd_mem_i       (rd_MEM),
        .regwrite_mem_i (regwrite_MEM),
        .memread_mem_i  (memread_MEM),
        .rd_wb_i        (rd_WB),
        .regwrite_wb_i  (regwrite_WB),
        .fwd_sel_o      (fwd1_raw)
    );

    fwd_unit #(.AW(REG_AW)) u_fwd2 (
        .rs_i           (rs2_EX),
        .rd_mem_i       (rd_MEM),
        .regwrite_mem_i (regwrite_MEM),
        .memread_mem_i  (memread_MEM),
        .rd_wb_i        (rd_WB),
        .regwrite_wb_i  (regwrite_WB),
        .fwd_sel_o      (fwd2_raw)
    );

    // Load data from MEM overrides any ALU forward for the same operand.
    assign fwd1_sel     = en1_q ? FWD_RF : fwd1_raw;
    assign fwd2_sel     = en2_q ? FWD_RF : fwd2_raw;
    assign stall_EN1_EX = en1_q;
    assign stall_EN2_EX = en2_q;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_ID, rs2_ID, rd_EX, rs1_EX, rs2_EX, rd_MEM, rd_WB;
    logic       rs1_used_ID, rs2_used_ID, memread_EX, regwrite_EX;
    logic       regwrite_MEM, memread_MEM, regwrite_WB, branch_taken_EX, mem_busy;

    logic        pc_hold, ifid_hold, idex_bubble, ifid_flush, pipe_freeze;
    logic        stall_EN1_EX, stall_EN2_EX;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic [31:0] stall_cnt;

    logic        s_pc_hold, s_ifid_hold, s_idex_bubble, s_ifid_flush, s_pipe_freeze;
    logic        s_en1, s_en2;
    logic [1:0]  s_fwd1, s_fwd2;
    logic [3:0]  s_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    bit     m_f1, m_f2;     // load-data operand flags currently driven
    bit     m_slot;         // next unfrozen cycle is the bubble follow-up cycle
    longint m_cnt;          // unbounded count of hold cycles

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .memread_EX(memread_EX), .regwrite_EX(regwrite_EX),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM), .memread_MEM(memread_MEM),
        .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
        .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .pipe_freeze(pipe_freeze),
        .stall_EN1_EX(stall_EN1_EX), .stall_EN2_EX(stall_EN2_EX),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance to reach saturation quickly.
    hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .memread_EX(memread_EX), .regwrite_EX(regwrite_EX),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM), .memread_MEM(memread_MEM),
        .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
        .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy),
        .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .idex_bubble(s_idex_bubble),
        .ifid_flush(s_ifid_flush), .pipe_freeze(s_pipe_freeze),
        .stall_EN1_EX(s_en1), .stall_EN2_EX(s_en2),
        .fwd1_sel(s_fwd1), .fwd2_sel(s_fwd2), .stall_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input bit load_flag);
        if (load_flag) return 2'b00;
        if (regwrite_MEM && !memread_MEM && rd_MEM != 0 && rd_MEM == rs) return 2'b01;
        if (regwrite_WB && rd_WB != 0 && rd_WB == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
        rd_EX = 0; memread_EX = 0; regwrite_EX = 0; rs1_EX = 0; rs2_EX = 0;
        rd_MEM = 0; regwrite_MEM = 0; memread_MEM = 0; rd_WB = 0; regwrite_WB = 0;
        branch_taken_EX = 0; mem_busy = 0; rst = 0;
    endtask

    // Check one cycle against the model (inputs already driven), advance the
    // model, and move to the next negative edge.
    task automatic tick();
        bit hit1, hit2, load_hz;
        bit e_hold, e_bubble, e_flush, e_freeze;
        longint e_cnt, e_scnt;
        hit1    = rs1_used_ID && rs1_ID == rd_EX;
        hit2    = rs2_used_ID && rs2_ID == rd_EX;
        load_hz = memread_EX && regwrite_EX && rd_EX != 0 && (hit1 || hit2);
        e_freeze = mem_busy;
        e_hold   = mem_busy || (!branch_taken_EX && !m_slot && load_hz);
        e_flush  = !mem_busy && branch_taken_EX;
        e_bubble = !mem_busy && (branch_taken_EX || (!m_slot && load_hz));
        e_cnt    = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
        e_scnt   = (m_cnt > 15) ? 15 : m_cnt;
        #1;
        check("pc_hold",     pc_hold,      e_hold);
        check("ifid_hold",   ifid_hold,    e_hold);
        check("idex_bubble", idex_bubble,  e_bubble);
        check("ifid_flush",  ifid_flush,   e_flush);
        check("pipe_freeze", pipe_freeze,  e_freeze);
        check("stall_EN1",   stall_EN1_EX, m_f1);
        check("stall_EN2",   stall_EN2_EX, m_f2);
        check("fwd1_sel",    fwd1_sel,     ref_fwd(rs1_EX, m_f1));
        check("fwd2_sel",    fwd2_sel,     ref_fwd(rs2_EX, m_f2));
        check("stall_cnt",   stall_cnt,    e_cnt);
        check("sat_cnt",     s_cnt,        e_scnt);
        if (rst) begin
            m_f1 = 0; m_f2 = 0; m_slot = 0; m_cnt = 0;
        end else begin
            if (e_hold) m_cnt++;
            if (!mem_busy) begin
                if (m_slot || branch_taken_EX || !load_hz) begin
                    m_f1 = 0; m_f2 = 0; m_slot = 0;
                end else begin
                    m_f1 = hit1; m_f2 = hit2; m_slot = 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_cycle();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        idle_inputs();
        rd_EX = rd; memread_EX = 1; regwrite_EX = 1;
        rs1_ID = r1; rs2_ID = r2; rs1_used_ID = 1; rs2_used_ID = 1;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_f1 = 0; m_f2 = 0; m_slot = 0; m_cnt = 0;

        // Reset state
        tick();

        // lw x5 ; add x6,x5,x1
        load_use(5, 5, 1);
        tick();
        idle_inputs();
        tick();
        tick();
        check("t1_cnt", stall_cnt, 32'd1);

        // lw x0 with consumer of x0: no stall
        reset_cycle();
        load_use(0, 0, 0);
        tick();
        idle_inputs();
        tick();
        check("t2_en1", stall_EN1_EX, 1'b0);

        // lw x7 ; consumer rs2=7 ; memory busy three cycles
        reset_cycle();
        load_use(7, 2, 7);
        tick();
        idle_inputs();
        mem_busy = 1;
        repeat (3) tick();
        mem_busy = 0;
        check("t3_en2_rel", stall_EN2_EX, 1'b1);
        tick();
        tick();
        check("t3_cnt", stall_cnt, 32'd4);

        // Forward priority MEM over WB, then WB alone
        reset_cycle();
        rd_MEM = 3; regwrite_MEM = 1; rd_WB = 3; regwrite_WB = 1; rs1_EX = 3;
        tick();
        check("t4_mem", fwd1_sel, 2'b01);
        regwrite_MEM = 0;
        tick();
        check("t4_wb", fwd1_sel, 2'b10);

        // Taken branch alongside a load-use pattern
        reset_cycle();
        load_use(4, 4, 0);
        branch_taken_EX = 1;
        tick();
        idle_inputs();
        check("t5_flags", {stall_EN1_EX, stall_EN2_EX}, 2'b00);
        tick();

        // Reset asserted during the bubble follow-up cycle
        reset_cycle();
        load_use(9, 9, 9);
        tick();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
        check("t6_cnt", stall_cnt, 32'd0);

        // Saturation of the narrow counter
        idle_inputs();
        mem_busy = 1;
        repeat (20) tick();
        check("t7_sat", s_cnt, 4'hF);
        reset_cycle();

        // Randomized traffic with a small register pool to make hazards frequent
        for (int i = 0; i < 800; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            rs1_ID          = 5'($urandom_range(0, 3));
            rs2_ID          = 5'($urandom_range(0, 3));
            rs1_used_ID     = 1'($urandom_range(0, 1));
            rs2_used_ID     = 1'($urandom_range(0, 1));
            rd_EX           = 5'($urandom_range(0, 3));
            memread_EX      = 1'($urandom_range(0, 1));
            regwrite_EX     = ($urandom_range(0, 3) != 0);
            rs1_EX          = 5'($urandom_range(0, 3));
            rs2_EX          = 5'($urandom_range(0, 3));
            rd_MEM          = 5'($urandom_range(0, 3));
            regwrite_MEM    = 1'($urandom_range(0, 1));
            memread_MEM     = ($urandom_range(0, 3) == 0);
            rd_WB           = 5'($urandom_range(0, 3));
            regwrite_WB     = 1'($urandom_range(0, 1));
            branch_taken_EX = ($urandom_range(0, 7) == 0);
            mem_busy        = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
